ddr_crc5_engine: RTL and testbench

- Serial CRC-5 engine for the HDR-DDR receive path, directly downstream of the RX deserializer.
- Consumes deserialized bytes plus frame-control strobes (enable, data-valid, last-byte) and computes the running CRC-5 over all payload bytes of a frame.
- Presents the final CRC value and a valid flag back to the RX block, which compares it against the received CRC field.
- Processes one bit per system clock, MSB first, with a one-deep skid buffer so back-to-back byte strobes are not lost.

---
 rtl/ddr_crc5_engine.sv | 193 +++++++++++++++++++
 tb/tb_ddr_crc5_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_crc5_engine.sv
// ddr_crc5_engine
//   Serial CRC-5 engine for the HDR-DDR receive path. Consumes deserialized payload bytes
//   and applies one bit per clock, MSB first, to a CRC-5 register. A one-deep skid buffer
//   absorbs a byte that arrives while the previous one is still shifting.
//
// Ports
//   i_sys_clk          system clock
//   i_sys_rst          asynchronous active-high reset
//   i_crc_en           frame active; rising edge starts a new frame
//   i_crc_data_valid   one-cycle strobe, i_crc_data holds a complete byte
//   i_crc_data         payload byte, MSB first
//   i_crc_last_byte    one-cycle strobe, no further bytes in this frame
//   o_crc_value        final CRC-5 of the frame, held until the next o_crc_valid
//   o_crc_valid        one-cycle pulse when o_crc_value is final
//   o_crc_busy         shifting or holding a pending byte
//   o_crc_overflow     sticky, a byte was dropped because both slots were full
module ddr_crc5_engine #(
   parameter int unsigned DATA_W = 8,
   parameter logic [4:0]  POLY   = 5'h05,
   parameter logic [4:0]  SEED   = 5'h1F
) (
   input  logic              i_sys_clk,
   input  logic              i_sys_rst,
   input  logic              i_crc_en,
   input  logic              i_crc_data_valid,
   input  logic [DATA_W-1:0] i_crc_data,
   input  logic              i_crc_last_byte,
   output logic [4:0]        o_crc_value,
   output logic              o_crc_valid,
   output logic              o_crc_busy,
   output logic              o_crc_overflow
);

   localparam int unsigned   CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e              state_q, state_d;
   logic [4:0]          crc_q, crc_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0]   skid_q, skid_d;
   logic                skid_vld_q, skid_vld_d;
   logic                fin_q, fin_d;
   logic                en_q;
   logic [4:0]          value_q, value_d;
   logic                valid_q, valid_d;
   logic                ovf_q, ovf_d;

   logic                start;
   logic                acc;
   logic                last;
   state_e              state_cur;
   logic [4:0]          crc_cur;
   logic                skid_vld_cur;
   logic                fin_cur;
   logic                fb;
   logic [4:0]          crc_step;

   assign start = i_crc_en & ~en_q;
   assign acc   = i_crc_en & i_crc_data_valid;
   assign last  = i_crc_en & i_crc_last_byte;

   // A frame start wipes the slate first; the rest of the next-state logic then runs on
   // the wiped view, so a byte coincident with the start is still accepted into the new frame.
   assign state_cur    = start ? StIdle : state_q;
   assign crc_cur      = start ? SEED   : crc_q;
   assign skid_vld_cur = start ? 1'b0   : skid_vld_q;
   assign fin_cur      = start ? 1'b0   : fin_q;

   assign fb       = crc_cur[4] ^ shift_q[DATA_W-1];
   assign crc_step = {crc_cur[3:0], 1'b0} ^ (fb ? POLY : 5'h00);

   always_comb begin
      state_d    = state_cur;
      crc_d      = crc_cur;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_cur;
      fin_d      = fin_cur | last;
      ovf_d      = start ? 1'b0 : ovf_q;
      value_d    = value_q;
      valid_d    = 1'b0;

      unique case (state_cur)
         StIdle: begin
            if (skid_vld_cur) begin
               shift_d = skid_q;
               cnt_d   = '0;
               state_d = StShift;
               if (acc) begin
                  skid_d = i_crc_data;
               end else begin
                  skid_vld_d = 1'b0;
               end
            end else if (acc) begin
               shift_d = i_crc_data;
               cnt_d   = '0;
               state_d = StShift;
            end else if (fin_cur | last) begin
               state_d = StDone;
            end
         end

         StShift: begin
            crc_d   = crc_step;
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               cnt_d = '0;
               if (skid_vld_cur) begin
                  // Skid drains into the shifter; a byte arriving now refills the skid.
                  shift_d = skid_q;
                  if (acc) begin
                     skid_d = i_crc_data;
                  end else begin
                     skid_vld_d = 1'b0;
                  end
               end else if (acc) begin
                  // Back-to-back byte: load straight in, no idle bubble.
                  shift_d = i_crc_data;
               end else if (fin_cur | last) begin
                  state_d = StDone;
               end else begin
                  state_d = StIdle;
               end
            end else if (acc) begin
               if (!skid_vld_cur) begin
                  skid_d     = i_crc_data;
                  skid_vld_d = 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end

         StDone: begin
            value_d = crc_cur;
            valid_d = 1'b1;
            fin_d   = last;
            state_d = StIdle;
            if (acc) begin
               if (!skid_vld_cur) begin
                  skid_d     = i_crc_data;
                  skid_vld_d = 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state_q    <= StIdle;
         crc_q      <= SEED;
         shift_q    <= '0;
         cnt_q      <= '0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         fin_q      <= 1'b0;
         en_q       <= 1'b0;
         value_q    <= 5'h00;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
         fin_q      <= fin_d;
         en_q       <= i_crc_en;
         value_q    <= value_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
      end
   end

   assign o_crc_value    = value_q;
   assign o_crc_valid    = valid_q;
   assign o_crc_busy     = (state_q == StShift) | skid_vld_q;
   assign o_crc_overflow = ovf_q;

endmodule

// File: tb/tb_ddr_crc5_engine.sv
// Self-checking bench for ddr_crc5_engine: directed frames with literal expectations plus a
// transaction-level reference model (byte start/finish times and CRC over accepted bytes).
module tb_ddr_crc5_engine;

   logic       clk;
   logic       rst;
   logic       en;
   logic       dv;
   logic [7:0] data;
   logic       last;
   logic [4:0] o_crc_value;
   logic       o_crc_valid;
   logic       o_crc_busy;
   logic       o_crc_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, written only by the model process.
   int         cyc = 0;
   logic       m_en_prev;
   logic [4:0] m_crc;
   int         m_fmax;
   int         m_lasts;
   int         m_exp_cyc;
   logic [4:0] m_value;
   logic       m_valid_now;
   logic       m_ovf;

   ddr_crc5_engine dut (
      .i_sys_clk        (clk),
      .i_sys_rst        (rst),
      .i_crc_en         (en),
      .i_crc_data_valid (dv),
      .i_crc_data       (data),
      .i_crc_last_byte  (last),
      .o_crc_value      (o_crc_value),
      .o_crc_valid      (o_crc_valid),
      .o_crc_busy       (o_crc_busy),
      .o_crc_overflow   (o_crc_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
      logic [4:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ 5'h05;
         else             r = {r[3:0], 1'b0};
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int max_cyc, output int lat);
      lat = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         @(posedge clk);
         #1;
         if (o_crc_valid) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) check("valid_timeout", 32'd0, 32'd1);
   endtask

   // Model: each accepted byte starts shifting at max(accept, previous finish) and finishes
   // 8 cycles later; a byte is dropped if another accepted byte has not started yet.
   initial begin
      int s;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            m_en_prev   = 1'b0;
            m_crc       = 5'h1F;
            m_fmax      = cyc;
            m_lasts     = cyc;
            m_exp_cyc   = -1;
            m_value     = 5'h00;
            m_valid_now = 1'b0;
            m_ovf       = 1'b0;
         end else begin
            m_valid_now = 1'b0;
            if (en && !m_en_prev) begin
               m_crc     = 5'h1F;
               m_fmax    = cyc;
               m_lasts   = cyc;
               m_exp_cyc = -1;
               m_ovf     = 1'b0;
            end else if (m_exp_cyc == cyc) begin
               m_valid_now = 1'b1;
               m_value     = m_crc;
               m_exp_cyc   = -1;
            end
            if (en && dv) begin
               if (m_lasts > cyc) begin
                  m_ovf = 1'b1;
               end else begin
                  s       = (m_fmax > cyc) ? m_fmax : cyc;
                  m_lasts = s;
                  m_fmax  = s + 8;
                  m_crc   = crc5_byte(m_crc, data);
               end
            end
            if (en && last) m_exp_cyc = ((m_fmax > cyc) ? m_fmax : cyc) + 1;
            m_en_prev = en;
         end
      end
   end

   // Compare process: outputs against the model every cycle outside reset.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("valid",    32'(o_crc_valid),    32'(m_valid_now));
            check("value",    32'(o_crc_value),    32'(m_value));
            check("busy",     32'(o_crc_busy),     32'(cyc < m_fmax));
            check("overflow", 32'(o_crc_overflow), 32'(m_ovf));
         end
      end
   end

   initial begin
      int lat;
      rst = 1'b1; en = 1'b0; dv = 1'b0; last = 1'b0; data = 8'h00;
      tick(); tick();
      check("rst_valid", 32'(o_crc_valid),    32'd0);
      check("rst_value", 32'(o_crc_value),    32'd0);
      check("rst_busy",  32'(o_crc_busy),     32'd0);
      check("rst_ovf",   32'(o_crc_overflow), 32'd0);
      rst = 1'b0;
      tick();

      // Single byte 00 with coincident last
      en = 1'b1; tick();
      data = 8'h00; dv = 1'b1; last = 1'b1; tick();
      dv = 1'b0; last = 1'b0;
      wait_valid(20, lat);
      check("single_lat",   32'(lat),         32'd9);
      check("single_value", 32'(o_crc_value), 32'h0F);
      en = 1'b0; tick();

      // Two bytes back-to-back through the skid
      en = 1'b1; tick();
      data = 8'h00; dv = 1'b1; tick();
      last = 1'b1; tick();
      dv = 1'b0; last = 1'b0;
      wait_valid(30, lat);
      check("b2b_lat",   32'(lat),            32'd16);
      check("b2b_value", 32'(o_crc_value),    32'h01);
      check("b2b_ovf",   32'(o_crc_overflow), 32'd0);
      en = 1'b0; tick();

      // Overflow: three consecutive strobes, third dropped
      en = 1'b1; tick();
      dv = 1'b1;
      data = 8'($urandom); tick();
      data = 8'($urandom); tick();
      data = 8'($urandom); tick();
      dv = 1'b0;
      check("ovf_set", 32'(o_crc_overflow), 32'd1);
      last = 1'b1; tick();
      last = 1'b0;
      wait_valid(30, lat);
      check("ovf_lat",    32'(lat),            32'd14);
      check("ovf_sticky", 32'(o_crc_overflow), 32'd1);
      en = 1'b0; tick();
      en = 1'b1; tick();
      check("ovf_clear", 32'(o_crc_overflow), 32'd0);

      // Empty frame
      last = 1'b1; tick();
      last = 1'b0;
      wait_valid(5, lat);
      check("empty_lat",   32'(lat),         32'd1);
      check("empty_value", 32'(o_crc_value), 32'h1F);
      en = 1'b0; tick();

      // Byte landing on the final-bit cycle, then a late last
      en = 1'b1; tick();
      dv = 1'b1; data = 8'($urandom); tick();
      dv = 1'b0; repeat (7) tick();
      dv = 1'b1; data = 8'($urandom); tick();
      dv = 1'b0; repeat (11) tick();
      check("late_idle", 32'(o_crc_busy), 32'd0);
      last = 1'b1; tick();
      last = 1'b0;
      wait_valid(5, lat);
      check("late_lat", 32'(lat), 32'd1);
      en = 1'b0; tick();

      // en falls with finalize pending; strobe while en=0 ignored
      en = 1'b1; tick();
      dv = 1'b1; data = 8'($urandom); last = 1'b1; tick();
      en = 1'b0; data = 8'($urandom); last = 1'b0; tick();
      dv = 1'b0;
      wait_valid(20, lat);
      check("enfall_lat", 32'(lat), 32'd8);
      tick();

      // Abort mid-shift by a new frame start
      en = 1'b1; tick();
      dv = 1'b1; data = 8'($urandom); last = 1'b1; tick();
      dv = 1'b0; last = 1'b0;
      repeat (3) tick();
      en = 1'b0; tick();
      en = 1'b1; tick();
      check("abort_idle", 32'(o_crc_busy), 32'd0);
      dv = 1'b1; data = 8'h00; last = 1'b1; tick();
      dv = 1'b0; last = 1'b0;
      wait_valid(20, lat);
      check("abort_lat",   32'(lat),         32'd9);
      check("abort_value", 32'(o_crc_value), 32'h0F);
      en = 1'b0; tick();

      // Reset mid-shift
      en = 1'b1; tick();
      dv = 1'b1; data = 8'($urandom); last = 1'b1; tick();
      dv = 1'b0; last = 1'b0;
      repeat (3) tick();
      rst = 1'b1; en = 1'b0;
      #1;
      check("midrst_valid", 32'(o_crc_valid),    32'd0);
      check("midrst_value", 32'(o_crc_value),    32'd0);
      check("midrst_busy",  32'(o_crc_busy),     32'd0);
      check("midrst_ovf",   32'(o_crc_overflow), 32'd0);
      tick(); tick();
      rst = 1'b0;
      repeat (15) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
